// File: rtl/dac_stat_pkg.sv
// Shared types and constants for the DAC channel statistics collector.
package dac_stat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stat_state_t;

  localparam int unsigned STAT_CFG_CLEAR_BIT = 0;
  localparam int unsigned STAT_CFG_CONT_BIT  = 1;

  // Fill bits for the accumulator reset values, replicated to the sample width.
  localparam logic MIN_INIT = 1'b1;
  localparam logic MAX_INIT = 1'b0;

endpackage

// File: rtl/dac_stat_acc.sv
// Min/max/saturating-count accumulator for one statistics window.
module dac_stat_acc
  import dac_stat_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          seed,
  input  logic          en,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] acc_min,
  output logic [DW-1:0] acc_max,
  output logic [CW-1:0] acc_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_min   <= {DW{MIN_INIT}};
      acc_max   <= {DW{MAX_INIT}};
      acc_count <= '0;
    end else if (clr) begin
      acc_min   <= {DW{MIN_INIT}};
      acc_max   <= {DW{MAX_INIT}};
      acc_count <= '0;
    end else if (seed) begin
      // The sample landing in a window-end cycle opens the next window.
      acc_min   <= sample;
      acc_max   <= sample;
      acc_count <= CW'(1);
    end else if (en) begin
      if (sample < acc_min) acc_min <= sample;
      if (sample > acc_max) acc_max <= sample;
      if (acc_count != '1) acc_count <= acc_count + CW'(1);
    end
  end

endmodule

// File: rtl/dac_channel_stat.sv
// Per-channel min/max/count statistics over one-shot or auto-rearming sample windows.
module dac_channel_stat
  import dac_stat_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic [1:0]    stat_cfg,
  input  logic [CW-1:0] stat_limit,
  output logic [DW-1:0] stat_min,
  output logic [DW-1:0] stat_max,
  output logic [CW-1:0] stat_count,
  output logic          stat_done
);

  stat_state_t   state, state_next;
  logic          clear, cont, win_end;
  logic          acc_clr, acc_seed, acc_en, pub_acc, done_next;
  logic [DW-1:0] acc_min, acc_max;
  logic [CW-1:0] acc_count;

  assign clear   = stat_cfg[STAT_CFG_CLEAR_BIT];
  assign cont    = stat_cfg[STAT_CFG_CONT_BIT];
  // Live limit: lowering it below the running count ends the window at once.
  assign win_end = (state == RUN) && (stat_limit != '0) && (acc_count >= stat_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = RUN;
        RUN:     if (win_end && !cont) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_clr   = 1'b0;
    acc_seed  = 1'b0;
    acc_en    = 1'b0;
    pub_acc   = 1'b0;
    done_next = 1'b0;
    if (clear) begin
      acc_clr = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (win_end) begin
            pub_acc   = 1'b1;
            done_next = 1'b1;
            if (cont) begin
              acc_seed = sample_valid;
              acc_clr  = !sample_valid;
            end
          end else begin
            acc_en  = sample_valid;
            pub_acc = !cont;
          end
        end
        DONE: begin
          done_next = 1'b1;
          pub_acc   = !cont;
        end
        default: ;
      endcase
    end
  end

  dac_stat_acc #(.DW(DW), .CW(CW)) u_acc (
    .clk       (clk),
    .reset     (reset),
    .clr       (acc_clr),
    .seed      (acc_seed),
    .en        (acc_en),
    .sample    (sample),
    .acc_min   (acc_min),
    .acc_max   (acc_max),
    .acc_count (acc_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_min   <= {DW{MIN_INIT}};
      stat_max   <= {DW{MAX_INIT}};
      stat_count <= '0;
      stat_done  <= 1'b0;
    end else begin
      stat_done <= done_next;
      if (clear) begin
        stat_min   <= {DW{MIN_INIT}};
        stat_max   <= {DW{MAX_INIT}};
        stat_count <= '0;
      end else if (pub_acc) begin
        stat_min   <= acc_min;
        stat_max   <= acc_max;
        stat_count <= acc_count;
      end
    end
  end

endmodule

// File: tb/tb_dac_channel_stat.sv
// Bench for dac_channel_stat: window-level reference model plus directed literal checks.
module tb_dac_channel_stat;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sample;
  logic [1:0]  stat_cfg;
  logic [31:0] stat_limit;
  logic [7:0]  stat_min, stat_max;
  logic [31:0] stat_count;
  logic        stat_done;

  // Narrow-count instance, unlimited window, to reach saturation quickly.
  logic [3:0]  sat_limit = '0;
  logic [7:0]  sat_min, sat_max;
  logic [3:0]  sat_count;
  logic        sat_done;

  always #5 clk = ~clk;

  dac_channel_stat #(.DW(8), .CW(32)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .stat_cfg(stat_cfg), .stat_limit(stat_limit),
    .stat_min(stat_min), .stat_max(stat_max), .stat_count(stat_count), .stat_done(stat_done)
  );

  dac_channel_stat #(.DW(8), .CW(4)) dut_sat (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .stat_cfg(stat_cfg), .stat_limit(sat_limit),
    .stat_min(sat_min), .stat_max(sat_max), .stat_count(sat_count), .stat_done(sat_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the current window is a plain list of accepted samples.
  bit              m_run = 1'b0, m_fin = 1'b0;
  logic [7:0]      win[$];
  longint unsigned m_cnt = 0;
  logic [7:0]      e_min = 8'hFF, e_max = 8'h00;
  longint unsigned e_cnt = 0;
  bit              e_done = 1'b0;
  bit              ended;

  function automatic void publish();
    e_min = 8'hFF;
    e_max = 8'h00;
    foreach (win[i]) begin
      if (win[i] < e_min) e_min = win[i];
      if (win[i] > e_max) e_max = win[i];
    end
    e_cnt = m_cnt;
  endfunction

  function automatic void model_clear();
    m_run = 1'b0; m_fin = 1'b0; win.delete(); m_cnt = 0;
    e_min = 8'hFF; e_max = 8'h00; e_cnt = 0; e_done = 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || stat_cfg[0]) begin
      model_clear();
    end else if (!m_run && !m_fin) begin
      m_run = 1'b1;
      e_done = 1'b0;
    end else if (m_fin) begin
      e_done = 1'b1;
    end else begin
      ended = (stat_limit != 0) && (m_cnt >= stat_limit);
      if (!stat_cfg[1] || ended) publish();
      e_done = ended;
      if (ended && !stat_cfg[1]) begin
        m_run = 1'b0;
        m_fin = 1'b1;
      end else begin
        if (ended) begin
          win.delete();
          m_cnt = 0;
        end
        if (sample_valid) begin
          win.push_back(sample);
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("model_min",   stat_min,   e_min);
    chk("model_max",   stat_max,   e_max);
    chk("model_count", stat_count, e_cnt);
    chk("model_done",  stat_done,  e_done);
  end

  task automatic step(input logic v, input logic [7:0] d);
    sample_valid = v;
    sample       = d;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cycle();
    stat_cfg = 2'b01;
    step(1'b1, 8'hAA);
  endtask

  int pulses;

  initial begin
    reset = 1'b1; stat_cfg = 2'b01; stat_limit = '0; sample_valid = 1'b0; sample = '0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("rst_min", stat_min, 8'hFF);
    chk("rst_max", stat_max, 8'h00);
    chk("rst_count", stat_count, 0);
    chk("rst_done", stat_done, 0);
    reset = 1'b0;

    // One-shot, limit 4
    stat_cfg = 2'b00; stat_limit = 4;
    step(1'b0, 8'h00);
    step(1'b1, 8'h40); step(1'b1, 8'h10); step(1'b1, 8'h90); step(1'b1, 8'h20);
    step(1'b1, 8'h00);
    chk("os_done", stat_done, 1);
    chk("os_min", stat_min, 8'h10);
    chk("os_max", stat_max, 8'h90);
    chk("os_count", stat_count, 4);
    step(1'b1, 8'h00);
    chk("os_hold_min", stat_min, 8'h10);
    chk("os_hold_count", stat_count, 4);

    // Continuous, limit 3, stream 5 7 3 9 1 8
    clear_cycle();
    stat_cfg = 2'b10; stat_limit = 3;
    step(1'b0, 8'h00);
    step(1'b1, 8'd5); step(1'b1, 8'd7); step(1'b1, 8'd3);
    step(1'b1, 8'd9);
    chk("cont_w1_done", stat_done, 1);
    chk("cont_w1_min", stat_min, 3);
    chk("cont_w1_max", stat_max, 7);
    chk("cont_w1_count", stat_count, 3);
    step(1'b1, 8'd1);
    chk("cont_pulse_low", stat_done, 0);
    chk("cont_hold_max", stat_max, 7);
    step(1'b1, 8'd8);
    step(1'b0, 8'd0);
    chk("cont_w2_done", stat_done, 1);
    chk("cont_w2_min", stat_min, 1);
    chk("cont_w2_max", stat_max, 9);
    chk("cont_w2_count", stat_count, 3);

    // Continuous, limit 2, valid always high: windows tile
    clear_cycle();
    stat_cfg = 2'b10; stat_limit = 2;
    step(1'b1, 8'h55);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom));
      if (stat_done) pulses++;
    end
    step(1'b0, 8'h00);
    if (stat_done) pulses++;
    chk("tile_pulses", pulses, 20);

    // Unlimited window and count saturation
    clear_cycle();
    stat_cfg = 2'b00; stat_limit = 0;
    step(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    chk("unl_count", stat_count, 10);
    chk("unl_min", stat_min, 8'hFF);
    chk("unl_max", stat_max, 8'hFF);
    chk("unl_done", stat_done, 0);
    chk("sat_count10", sat_count, 10);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    chk("unl_count20", stat_count, 20);
    chk("sat_count", sat_count, 4'hF);
    chk("sat_min", sat_min, 8'hFF);
    chk("sat_done", sat_done, 0);

    // Limit lowered below the running count
    clear_cycle();
    stat_cfg = 2'b00; stat_limit = 100;
    step(1'b0, 8'h00);
    for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom));
    stat_limit = 20;
    step(1'b0, 8'h00);
    chk("lower_done", stat_done, 1);
    chk("lower_count", stat_count, 50);
    step(1'b1, 8'h00);
    chk("lower_hold_count", stat_count, 50);

    // Mid-window clear
    clear_cycle();
    stat_cfg = 2'b00; stat_limit = 0;
    step(1'b0, 8'h00);
    step(1'b1, 8'h33); step(1'b1, 8'h44); step(1'b1, 8'h22);
    step(1'b0, 8'h00);
    chk("pre_clr_count", stat_count, 3);
    stat_cfg = 2'b01;
    step(1'b1, 8'h11);
    chk("clr_min", stat_min, 8'hFF);
    chk("clr_max", stat_max, 8'h00);
    chk("clr_count", stat_count, 0);
    chk("clr_done", stat_done, 0);

    // Async reset with a sample pending, between clock edges
    stat_cfg = 2'b00;
    step(1'b0, 8'h00);
    step(1'b1, 8'h70); step(1'b1, 8'h08);
    step(1'b1, 8'h50);
    chk("pre_rst_count", stat_count, 2);
    #1 reset = 1'b1;
    #1;
    chk("arst_min", stat_min, 8'hFF);
    chk("arst_max", stat_max, 8'h00);
    chk("arst_count", stat_count, 0);
    chk("arst_done", stat_done, 0);
    #1 reset = 1'b0;
    step(1'b0, 8'h00);

    // Randomized traffic against the model
    stat_limit = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) stat_cfg[1] = ~stat_cfg[1];
      stat_cfg[0] = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) stat_limit = 32'($urandom_range(0, 6));
      step(($urandom_range(0, 9) < 7), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_channel_stat.md
Name: dac_channel_stat

Overview:
- Per-channel statistics collector on the DAC sample stream; sits downstream of the channel mux/gain/offset/filter datapath, tapping the final 8-bit DAC code.
- Measures min, max and sample count over a window of stat_limit samples.
- Takes its configuration (stat_cfg, stat_limit) from the channel APB register block and returns stat_min, stat_max and stat_count to it for readback.
- Supports one-shot and continuous (auto-rearm) windows.

Parameters:
- DW, 8, sample width (unsigned offset-binary DAC code).
- CW, 32, sample-count width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  sample strobe; one sample accepted per cycle when high.
- sample  in  DW  DAC code, unsigned.
- stat_cfg  in  2  bit0 = clear (held high: block idle and cleared); bit1 = mode (0 one-shot, 1 continuous).
- stat_limit  in  CW  window length in samples; 0 = unlimited.
- stat_min  out  DW  published minimum.
- stat_max  out  DW  published maximum.
- stat_count  out  CW  published sample count.
- stat_done  out  1  one-shot: level, high while DONE; continuous: 1-cycle pulse per completed window.

Behaviour:
- Reset is clk-independent and asynchronous. Reset values:
  - state = IDLE.
  - acc_min = all-ones; acc_max = 0; acc_count = 0.
  - stat_min = all-ones; stat_max = 0; stat_count = 0.
  - stat_done = 0.
- Clear (stat_cfg[0]=1) has priority over everything else:
  - Next cycle: state = IDLE, accumulators and outputs back to their reset values, stat_done = 0.
  - Samples are ignored while clear is high.
- IDLE -> RUN on the first cycle with stat_cfg[0]=0. No sample is accepted in that cycle.
- RUN, sample accept (sample_valid=1 and no window end this cycle):
  - acc_min <= min(acc_min, sample).
  - acc_max <= max(acc_max, sample).
  - acc_count <= acc_count + 1, saturating at all-ones.
  - Comparisons are unsigned.
- Window end: evaluated each RUN cycle as (stat_limit != 0) && (acc_count >= stat_limit).
  - Uses the live stat_limit. If software lowers the limit below acc_count, the window ends on the next RUN cycle.
- Window end, one-shot (stat_cfg[1]=0):
  - Next state = DONE; stat_done = 1.
  - A sample arriving in the end cycle is dropped.
- Window end, continuous (stat_cfg[1]=1):
  - stat_min/max/count <= current acc values (the completed window).
  - stat_done pulses for 1 cycle.
  - Accumulators restart. If sample_valid is high in the end cycle, that sample seeds the new window: acc_min = acc_max = sample, acc_count = 1. Otherwise accumulators return to reset values.
  - State stays RUN.
- Published outputs:
  - One-shot: stat_* <= acc_* every cycle in RUN and DONE, i.e. a 1-cycle-lagged live view.
  - Continuous: stat_* change only at window end.
- DONE: all samples ignored; outputs hold; exit only via clear.
- Mode bit changed mid-window takes effect from the next cycle. Accumulators are not disturbed.
- stat_limit = 0: the window never ends; acc_count saturates at 2^CW-1.
- An empty window (no samples) publishes min = all-ones, max = 0, count = 0; software reads this as "no data".
- Latency: a sample accepted at cycle N is reflected in acc at N+1 and in one-shot outputs at N+2.

Decomposition:
- Package dac_stat_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - STAT_CFG_CLEAR_BIT = 0 and STAT_CFG_CONT_BIT = 1;
  - reset constants MIN_INIT (all-ones) and MAX_INIT (0).
- One sub-module, dac_stat_acc: min/max/saturating-count accumulator with inputs clr, seed, en, sample.
- Top level holds the FSM, window-end compare and publish registers.

Test Plan:
- Reset then stat_cfg=0, limit=4, samples 0x40, 0x10, 0x90, 0x20 -> stat_done high; min=0x10, max=0x90, count=4. A following 5th sample 0x00 leaves outputs unchanged.
- Continuous, limit=3, back-to-back valid stream 5, 7, 3, 9, 1, 8 -> pulse after the first window with published (3, 7, 3). Sample 9 seeds window 2. Second publish is (1, 9, 3), window 2 = 9, 1, 8.
- Continuous, limit=2, sample_valid held high, so a sample always lands in the end cycle -> windows tile with no lost samples; the count of accepted samples equals 2 x stat_done pulses.
- limit=0, 10 samples of 0xFF -> no stat_done, count=10, min=max=0xFF. Forcing acc_count to 0xFFFFFFFE then sending 3 samples -> count=0xFFFFFFFF.
- One-shot, limit=100, after 50 samples write limit=20 -> DONE the next cycle with count=50.
- Mid-window: assert stat_cfg[0] for 1 cycle -> outputs read FF/00/0 and stat_done=0. Separately, assert async reset while a sample is valid -> outputs reset immediately, without a clock edge.
